// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache. Hits are served combinationally, and a
// miss refills one line through a request/ready handshake. Victims are chosen
// by round-robin per set, and the whole cache can be flushed.
module icache_set_assoc #(
  parameter int ADDR_W   = 20,
  parameter int LINE_W   = 128,
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic [31:0]       data_o,
  output logic              hit_o,
  output logic              miss_o,
  output logic              rqst_to_mem_o,
  output logic [ADDR_W-1:0] addr_to_mem_o
);

  localparam int OFF   = $clog2(LINE_W/8);
  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAG   = ADDR_W - OFF - IDX;
  localparam int WSEL  = OFF - 2;
  localparam int WORDS = LINE_W / 32;
  localparam int WAYW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [TAG-1:0]    r_tag   [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0] r_data  [NUM_WAYS][NUM_SETS];
  logic              r_valid [NUM_WAYS][NUM_SETS];
  logic [WAYW-1:0]   r_rr    [NUM_SETS];

  logic [ADDR_W-1:0] r_addr;
  logic [WAYW-1:0]   r_victim;
  logic              r_flush_pending;

  logic [IDX-1:0]    w_idx;
  logic [TAG-1:0]    w_tag;
  logic [WSEL-1:0]   w_word;
  logic              w_hit;
  logic [WAYW-1:0]   w_hit_way;
  logic [WAYW-1:0]   w_victim;
  logic              w_found_invalid;
  logic [LINE_W-1:0] w_line;
  logic [31:0]       w_words [WORDS];
  logic              w_start;
  logic              w_complete;
  logic              w_flush_done;
  logic [IDX-1:0]    w_r_set;
  logic [TAG-1:0]    w_r_tag;

  assign w_idx   = addr_i[OFF+IDX-1:OFF];
  assign w_tag   = addr_i[ADDR_W-1:OFF+IDX];
  assign w_word  = addr_i[OFF-1:2];
  assign w_r_set = r_addr[OFF+IDX-1:OFF];
  assign w_r_tag = r_addr[ADDR_W-1:OFF+IDX];

  // Tag lookup across all ways of the addressed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, falling back to the round-robin pointer.
  always_comb begin
    w_victim        = r_rr[w_idx];
    w_found_invalid = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!w_found_invalid && !r_valid[w][w_idx]) begin
        w_found_invalid = 1'b1;
        w_victim        = WAYW'(w);
      end
    end
  end

  // Word select from the hitting line.
  always_comb begin
    w_line = r_data[w_hit_way][w_idx];
    for (int unsigned i = 0; i < WORDS; i++) begin
      w_words[i] = w_line[32*i +: 32];
    end
    data_o = w_words[w_word];
  end

  // Next-state logic and requester-facing outputs.
  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_i && req_i && !w_hit) w_next_state = S_REQ;
      end
      S_REQ: w_next_state = S_WAIT;
      S_WAIT: begin
        if (mem_data_ready_i &&
            (mem_addr_i[ADDR_W-1:OFF] == r_addr[ADDR_W-1:OFF])) begin
          w_complete   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    w_start       = (r_state == S_IDLE) && (w_next_state == S_REQ);
    w_flush_done  = r_flush_pending || flush_i;
    hit_o         = req_i && w_hit && (r_state == S_IDLE);
    miss_o        = req_i && !hit_o;
    rqst_to_mem_o = (r_state == S_REQ);
    addr_to_mem_o = r_addr;
  end

  // State register, valid bits, replacement pointers and refill bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_victim        <= '0;
      r_flush_pending <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_rr[s] <= '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) r_valid[w][s] <= 1'b0;
      end
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && flush_i) begin
        for (int unsigned s = 0; s < NUM_SETS; s++)
          for (int unsigned w = 0; w < NUM_WAYS; w++) r_valid[w][s] <= 1'b0;
      end
      if (w_start) begin
        r_addr   <= {addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
        r_victim <= w_victim;
      end
      if (((r_state == S_REQ) || (r_state == S_WAIT)) && flush_i)
        r_flush_pending <= 1'b1;
      // A flush seen during the refill (including its final cycle) wins over
      // installing the line; the pointer still advances as for any refill.
      if (w_complete) begin
        r_flush_pending <= 1'b0;
        if (NUM_WAYS > 1) r_rr[w_r_set] <= r_rr[w_r_set] + 1'b1;
        if (w_flush_done) begin
          for (int unsigned s = 0; s < NUM_SETS; s++)
            for (int unsigned w = 0; w < NUM_WAYS; w++) r_valid[w][s] <= 1'b0;
        end else begin
          r_valid[r_victim][w_r_set] <= 1'b1;
        end
      end
    end
  end

  // Line payload and tag storage; only meaningful under a set valid bit.
  always_ff @(posedge clk_i) begin
    if (!rsn_i && w_complete && !w_flush_done) begin
      r_data[r_victim][w_r_set] <= mem_data_i;
      r_tag[r_victim][w_r_set]  <= w_r_tag;
    end
  end

endmodule

// File: tb/tb_icache_set_assoc.sv
// Bench for icache_set_assoc: directed stimulus, a behavioural cache model
// checked on every cycle, and literal expectations at key points.
module tb_icache_set_assoc;

  logic         clk = 1'b0;
  logic         rsn;
  logic         req;
  logic [19:0]  addr;
  logic         flush;
  logic         rdy;
  logic [127:0] mdata;
  logic [19:0]  maddr;
  logic [31:0]  data_o;
  logic         hit_o;
  logic         miss_o;
  logic         rqst_o;
  logic [19:0]  a2m_o;

  int n_chk  = 0;
  int n_pass = 0;

  icache_set_assoc #(.ADDR_W(20), .LINE_W(128), .NUM_SETS(4), .NUM_WAYS(2)) dut (
    .clk_i(clk), .rsn_i(rsn), .req_i(req), .addr_i(addr), .flush_i(flush),
    .mem_data_ready_i(rdy), .mem_data_i(mdata), .mem_addr_i(maddr),
    .data_o(data_o), .hit_o(hit_o), .miss_o(miss_o),
    .rqst_to_mem_o(rqst_o), .addr_to_mem_o(a2m_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 request cycle, 2 waiting for memory
  bit           m_live = 0;
  int           m_phase;
  bit           m_valid [2][4];
  int           m_tag   [2][4];
  logic [127:0] m_data  [2][4];
  int           m_rr    [4];
  int           m_addr;
  int           m_victim;
  bit           m_fp;

  function automatic int set_of(int a); return (a >> 4) % 4; endfunction
  function automatic int tag_of(int a); return a >> 6; endfunction
  function automatic int word_of(int a); return (a >> 2) % 4; endfunction

  function automatic int m_lookup(int a);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][set_of(a)] && m_tag[w][set_of(a)] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int w = 0; w < 2; w++) for (int s = 0; s < 4; s++) m_valid[w][s] = 0;
  endfunction

  always @(posedge clk) begin
    int a, s, v;
    a = int'(addr);
    if (rsn) begin
      m_clear();
      for (int s2 = 0; s2 < 4; s2++) m_rr[s2] = 0;
      m_phase = 0; m_addr = 0; m_victim = 0; m_fp = 0; m_live = 1;
    end else if (m_live) begin
      if (m_phase == 0) begin
        if (flush) m_clear();
        else if (req && m_lookup(a) < 0) begin
          s = set_of(a);
          v = -1;
          for (int w = 0; w < 2; w++) if (v < 0 && !m_valid[w][s]) v = w;
          if (v < 0) v = m_rr[s];
          m_victim = v;
          m_addr   = a & ~32'hF;
          m_phase  = 1;
        end
      end else if (m_phase == 1) begin
        if (flush) m_fp = 1;
        m_phase = 2;
      end else begin
        if (flush) m_fp = 1;
        if (rdy && (int'(maddr) >> 4) == (m_addr >> 4)) begin
          s = set_of(m_addr);
          if (m_fp) m_clear();
          else begin
            m_valid[m_victim][s] = 1;
            m_tag[m_victim][s]   = tag_of(m_addr);
            m_data[m_victim][s]  = mdata;
          end
          m_rr[s] = (m_rr[s] + 1) % 2;
          m_fp    = 0;
          m_phase = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int a, w;
    bit eh;
    logic [127:0] ln;
    if (m_live) begin
      a  = int'(addr);
      w  = m_lookup(a);
      eh = req && (m_phase == 0) && (w >= 0);
      chk("model_hit", 32'(hit_o), 32'(eh));
      chk("model_miss", 32'(miss_o), 32'(req && !eh));
      chk("model_rqst", 32'(rqst_o), 32'(m_phase == 1));
      chk("model_addr_to_mem", 32'(a2m_o), m_addr);
      if (eh) begin
        ln = m_data[w][set_of(a)] >> (32 * word_of(a));
        chk("model_data", data_o, ln[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic miss_start(input logic [19:0] a);
    req = 1; addr = a; flush = 0;
    @(negedge clk); chk("miss_start", 32'(miss_o), 1);
    tick();
  endtask

  // Called while in the request cycle; completes the refill.
  task automatic serve(input logic [19:0] a, input logic [127:0] ln);
    tick();
    rdy = 1; maddr = a; mdata = ln;
    tick();
    rdy = 0;
  endtask

  task automatic probe_hit(input logic [19:0] a, input logic [31:0] w);
    req = 1; addr = a;
    @(negedge clk); chk("probe_hit", 32'(hit_o), 1); chk("probe_data", data_o, w);
    tick();
    req = 0;
  endtask

  localparam logic [127:0] L1 = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
  localparam logic [127:0] L2 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [127:0] L3 = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
  localparam logic [127:0] L4 = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] L5 = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

  initial begin
    rsn = 1; req = 0; addr = '0; flush = 0; rdy = 0; maddr = '0; mdata = '0;
    tick(); tick();
    rsn = 0;
    @(negedge clk);
    chk("reset_rqst", 32'(rqst_o), 0);
    chk("reset_addr", 32'(a2m_o), 0);
    tick();

    // 1: first miss and minimum-latency refill
    req = 1; addr = 20'h00040;
    @(negedge clk); chk("t1_miss", 32'(miss_o), 1); chk("t1_nohit", 32'(hit_o), 0);
    tick();
    @(negedge clk); chk("t1_rqst", 32'(rqst_o), 1); chk("t1_addr", 32'(a2m_o), 32'h40);
    tick();
    rdy = 1; maddr = 20'h00040; mdata = L1; addr = 20'h00044;
    @(negedge clk); chk("t1_rqst_low", 32'(rqst_o), 0);
    tick();
    rdy = 0;
    @(negedge clk); chk("t1_hit", 32'(hit_o), 1); chk("t1_data", data_o, 32'hDEADBEEF);
    tick();

    // 2: associativity and round-robin eviction
    miss_start(20'h00440); serve(20'h00440, L2);
    probe_hit(20'h00040, 32'h11111111);
    probe_hit(20'h00440, 32'hA0A0A0A0);
    miss_start(20'h00840); serve(20'h00840, L3);
    probe_hit(20'h00448, 32'hA2A2A2A2);
    probe_hit(20'h0084C, 32'hB3B3B3B3);
    miss_start(20'h00040); serve(20'h00040, L1);

    // 4a + 3: idle flush, then a mismatching ready while waiting
    req = 0; flush = 1; tick(); flush = 0;
    miss_start(20'h00040);
    tick();
    rdy = 1; maddr = 20'h00080; mdata = L4;
    @(negedge clk); chk("t3_wait_nohit", 32'(hit_o), 0);
    tick();
    rdy = 0;
    @(negedge clk); chk("t3_still_wait", 32'(rqst_o), 0);
    tick();
    @(negedge clk); chk("t3_still_wait2", 32'(rqst_o), 0);
    rdy = 1; maddr = 20'h00040; mdata = L1;
    tick();
    rdy = 0;
    probe_hit(20'h00044, 32'hDEADBEEF);
    miss_start(20'h00080); serve(20'h00080, L4);
    miss_start(20'h00840); serve(20'h00840, L3);

    // 4b: flush during WAIT suppresses the install
    req = 0; flush = 1; tick(); flush = 0;
    miss_start(20'h00040);
    tick();
    flush = 1; tick(); flush = 0;
    rdy = 1; maddr = 20'h00040; mdata = L1; tick(); rdy = 0;
    miss_start(20'h00040); serve(20'h00040, L1);
    probe_hit(20'h00040, 32'h11111111);

    // 5: reset while waiting; a late response is ignored
    miss_start(20'h00200);
    tick();
    req = 0; tick();
    rsn = 1; tick(); rsn = 0;
    rdy = 1; maddr = 20'h00200; mdata = L5;
    @(negedge clk); chk("t5_rqst", 32'(rqst_o), 0); chk("t5_addr", 32'(a2m_o), 0);
    tick();
    rdy = 0;
    miss_start(20'h00200);
    @(negedge clk); chk("t5_was_idle", 32'(rqst_o), 1);
    serve(20'h00200, L5);
    probe_hit(20'h00204, 32'hD1D1D1D1);

    // 6: flush and a miss in the same cycle
    req = 1; addr = 20'h00300; flush = 1;
    @(negedge clk); chk("t6_miss", 32'(miss_o), 1);
    tick();
    flush = 0;
    @(negedge clk); chk("t6_no_rqst", 32'(rqst_o), 0);
    tick();
    @(negedge clk); chk("t6_rqst", 32'(rqst_o), 1); chk("t6_addr", 32'(a2m_o), 32'h300);
    serve(20'h00300, L2);
    probe_hit(20'h0030C, 32'hA3A3A3A3);

    req = 0; tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
